// File: rtl/fcb_pkg.sv
// Shared constants and types for the FCB configuration receiver.
// Adler-32 modulus, FSM encoding and status-vector bit positions.
package fcb_pkg;

  localparam logic [16:0] ADLER_MOD    = 17'd65521;
  localparam logic [15:0] ADLER_A_INIT = 16'd1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FINISH,
    S_DONE,
    S_READBACK
  } cfg_state_t;

  localparam int ST_DONE = 0;
  localparam int ST_OK   = 1;
  localparam int ST_ERR  = 2;
  localparam int ST_OVF  = 3;

  typedef logic [3:0] status_t;

endpackage

// File: rtl/fcb_adler_step.sv
// One Adler-32 byte update, purely combinational (zero latency, no flow control).
// Each sum stays below 2*MOD, so one conditional subtract replaces the modulo.
module fcb_adler_step
  import fcb_pkg::*;
(
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic [7:0]  i_byte,
  output logic [15:0] o_a,
  output logic [15:0] o_b
);

  logic [16:0] w_a_sum;
  logic [16:0] w_a_red;
  logic [16:0] w_b_sum;
  logic [16:0] w_b_red;

  assign w_a_sum = {1'b0, i_a} + {9'd0, i_byte};
  assign w_a_red = (w_a_sum >= ADLER_MOD) ? (w_a_sum - ADLER_MOD) : w_a_sum;
  assign o_a     = w_a_red[15:0];

  assign w_b_sum = {1'b0, i_b} + {1'b0, o_a};
  assign w_b_red = (w_b_sum >= ADLER_MOD) ? (w_b_sum - ADLER_MOD) : w_b_sum;
  assign o_b     = w_b_red[15:0];

endmodule

// File: rtl/fpga_cfg_rx.sv
// FCB config stream receiver: deserialises into the word store, Adler-32 checks, replays on tail.
// Done flags one cycle after the last bit; rd_data 1-cycle latency; no backpressure (bits qualified by valid).
module fpga_cfg_rx
  import fcb_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 128,
  parameter int LEN_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_reset,
  input  logic                     cfg_bit_valid,
  input  logic                     cfg_bit,
  input  logic [LEN_W-1:0]         cfg_len,
  input  logic [31:0]              exp_checksum,
  input  logic                     readback_req,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [31:0]              rd_data,
  output logic                     tail_bit,
  output logic                     tail_valid,
  output logic                     cfg_done,
  output logic                     chk_ok,
  output logic                     chk_err,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);

  cfg_state_t        r_state;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_bit_cnt;
  logic [LEN_W-1:0]  r_rd_ptr;
  logic [WORD_W-2:0] r_word_sr;
  logic [6:0]        r_byte_sr;
  logic [AW:0]       r_wr_ptr;
  logic [15:0]       r_a;
  logic [15:0]       r_b;
  status_t           r_status;
  logic              r_tail_bit;
  logic              r_tail_valid;
  logic [WORD_W-1:0] r_rd_data;
  logic [WORD_W-1:0] r_mem [DEPTH];

  logic              w_accept;
  logic [LEN_W-1:0]  w_len_eff;
  logic [LEN_W-1:0]  w_bit_cnt_nxt;
  logic              w_last;
  logic              w_word_end;
  logic              w_byte_end;
  logic [WORD_W-1:0] w_word;
  logic [7:0]        w_byte;
  logic              w_mem_full;
  logic              w_mem_we;
  logic [WORD_W-1:0] w_rb_word;
  logic [15:0]       w_a_nxt;
  logic [15:0]       w_b_nxt;

  assign w_accept = reset && !cfg_reset && cfg_bit_valid &&
                    (((r_state == S_IDLE) && (cfg_len != '0)) || (r_state == S_LOAD));
  assign w_len_eff     = (r_state == S_IDLE) ? cfg_len : r_len;
  assign w_bit_cnt_nxt = r_bit_cnt + LEN_W'(1);
  assign w_last        = (w_bit_cnt_nxt == w_len_eff);
  assign w_word_end    = w_last || (r_bit_cnt[4:0] == 5'd31);
  assign w_byte_end    = w_last || (r_bit_cnt[2:0] == 3'd7);

  // Shifting left-aligns a short tail and pushes stale shift-register bits off the top.
  assign w_word = {r_word_sr, cfg_bit} << (5'd31 - r_bit_cnt[4:0]);
  assign w_byte = {r_byte_sr, cfg_bit} << (3'd7 - r_bit_cnt[2:0]);

  assign w_mem_full = (r_wr_ptr == (AW+1)'(DEPTH));
  assign w_mem_we   = w_accept && w_word_end && !w_mem_full;
  assign w_rb_word  = r_mem[r_rd_ptr[5 +: AW]];

  fcb_adler_step u_adler (
    .i_a    (r_a),
    .i_b    (r_b),
    .i_byte (w_byte),
    .o_a    (w_a_nxt),
    .o_b    (w_b_nxt)
  );

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[r_wr_ptr[AW-1:0]] <= w_word;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_len        <= '0;
      r_bit_cnt    <= '0;
      r_rd_ptr     <= '0;
      r_word_sr    <= '0;
      r_byte_sr    <= '0;
      r_wr_ptr     <= '0;
      r_a          <= ADLER_A_INIT;
      r_b          <= '0;
      r_status     <= '0;
      r_tail_bit   <= 1'b0;
      r_tail_valid <= 1'b0;
      r_rd_data    <= '0;
    end else if (cfg_reset) begin
      r_state      <= S_IDLE;
      r_len        <= '0;
      r_bit_cnt    <= '0;
      r_rd_ptr     <= '0;
      r_word_sr    <= '0;
      r_byte_sr    <= '0;
      r_wr_ptr     <= '0;
      r_a          <= ADLER_A_INIT;
      r_b          <= '0;
      r_status     <= '0;
      r_tail_bit   <= 1'b0;
      r_tail_valid <= 1'b0;
      r_rd_data    <= '0;
    end else begin
      r_rd_data <= r_mem[rd_addr];

      if (w_accept) begin
        r_word_sr <= {r_word_sr[WORD_W-3:0], cfg_bit};
        r_byte_sr <= {r_byte_sr[5:0], cfg_bit};
        r_bit_cnt <= w_bit_cnt_nxt;
        if (w_byte_end) begin
          r_a <= w_a_nxt;
          r_b <= w_b_nxt;
        end
        // Words past the store are dropped but still feed the checksum.
        if (w_word_end) begin
          if (w_mem_full) r_status[ST_OVF] <= 1'b1;
          else            r_wr_ptr <= r_wr_ptr + 1'b1;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_len   <= cfg_len;
            r_state <= w_last ? S_FINISH : S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_accept && w_last) r_state <= S_FINISH;
        end
        S_FINISH: begin
          r_status[ST_DONE] <= 1'b1;
          if ({r_b, r_a} == exp_checksum) r_status[ST_OK]  <= 1'b1;
          else                            r_status[ST_ERR] <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_tail_valid <= 1'b0;
          if (readback_req) begin
            r_rd_ptr <= '0;
            r_state  <= S_READBACK;
          end
        end
        S_READBACK: begin
          r_tail_valid <= 1'b1;
          r_tail_bit   <= w_rb_word[~r_rd_ptr[4:0]];
          r_rd_ptr     <= r_rd_ptr + LEN_W'(1);
          if (r_rd_ptr == (r_len - LEN_W'(1))) r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rd_data    = r_rd_data;
  assign tail_bit   = r_tail_bit;
  assign tail_valid = r_tail_valid;
  assign cfg_done   = r_status[ST_DONE];
  assign chk_ok     = r_status[ST_OK];
  assign chk_err    = r_status[ST_ERR];
  assign overflow   = r_status[ST_OVF];

endmodule

// File: tb/tb_fpga_cfg_rx.sv
// Bench for fpga_cfg_rx: full-depth and 2-word instances share one stimulus stream;
// expected done flags and replay bits are queued at issue time and checked by monitors.
module tb_fpga_cfg_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, cfg_reset, cfg_bit_valid, cfg_bit, readback_req;
  logic [15:0] cfg_len;
  logic [31:0] exp_checksum;
  logic [6:0]  rd_addr;
  logic        rd_addr2;

  logic [31:0] rd_data1, rd_data2;
  logic        tail_bit1, tail_valid1, done1, ok1, err1, ovf1;
  logic        tail_bit2, tail_valid2, done2, ok2, err2, ovf2;

  fpga_cfg_rx #(.WORD_W(32), .DEPTH(128), .LEN_W(16)) u_dut (
    .clk(clk), .reset(reset), .cfg_reset(cfg_reset), .cfg_bit_valid(cfg_bit_valid),
    .cfg_bit(cfg_bit), .cfg_len(cfg_len), .exp_checksum(exp_checksum),
    .readback_req(readback_req), .rd_addr(rd_addr), .rd_data(rd_data1),
    .tail_bit(tail_bit1), .tail_valid(tail_valid1), .cfg_done(done1),
    .chk_ok(ok1), .chk_err(err1), .overflow(ovf1)
  );

  fpga_cfg_rx #(.WORD_W(32), .DEPTH(2), .LEN_W(16)) u_dut_small (
    .clk(clk), .reset(reset), .cfg_reset(cfg_reset), .cfg_bit_valid(cfg_bit_valid),
    .cfg_bit(cfg_bit), .cfg_len(cfg_len), .exp_checksum(exp_checksum),
    .readback_req(readback_req), .rd_addr(rd_addr2), .rd_data(rd_data2),
    .tail_bit(tail_bit2), .tail_valid(tail_valid2), .cfg_done(done2),
    .chk_ok(ok2), .chk_err(err2), .overflow(ovf2)
  );

  int n_checks = 0;
  int n_errors = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  logic       tx[$];
  logic [2:0] q_done1[$];
  logic [2:0] q_done2[$];
  logic       q_tail1[$];
  logic       q_tail2[$];
  int         tail_seen;
  bit         chk_tail2 = 1'b0;
  logic       prev_done1 = 1'b0;
  logic       prev_done2 = 1'b0;

  // Monitors: pop expectations when the DUT raises done or drives a tail bit.
  always @(negedge clk) begin
    if (done1 && !prev_done1) begin
      if (q_done1.size() == 0) check("done1_unexpected", 1, 0);
      else check("done1_flags{ok,err,ovf}", {ok1, err1, ovf1}, q_done1.pop_front());
    end
    prev_done1 = done1;
  end

  always @(negedge clk) begin
    if (done2 && !prev_done2) begin
      if (q_done2.size() == 0) check("done2_unexpected", 1, 0);
      else check("done2_flags{ok,err,ovf}", {ok2, err2, ovf2}, q_done2.pop_front());
    end
    prev_done2 = done2;
  end

  always @(negedge clk) begin
    if (tail_valid1) begin
      tail_seen++;
      if (q_tail1.size() == 0) check("tail1_extra", 1, 0);
      else check("tail1_bit", tail_bit1, q_tail1.pop_front());
    end
  end

  always @(negedge clk) begin
    if (tail_valid2 && chk_tail2) begin
      if (q_tail2.size() == 0) check("tail2_extra", 1, 0);
      else check("tail2_bit", tail_bit2, q_tail2.pop_front());
    end
  end

  task automatic push_word(input logic [31:0] w, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) tx.push_back(w[i]);
  endtask

  task automatic expect_done(input logic ok, input logic err, input logic ov1, input logic ov2);
    q_done1.push_back({ok, err, ov1});
    q_done2.push_back({ok, err, ov2});
  endtask

  task automatic run_load(input int len, input logic [31:0] exp, input bit gaps);
    cfg_len = 16'(len);
    exp_checksum = exp;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (gaps && (i % 5 == 2)) begin
        cfg_bit_valid = 1'b0;
        @(negedge clk);
      end
      cfg_bit_valid = 1'b1;
      cfg_bit = tx[i];
    end
    @(negedge clk);
    cfg_bit_valid = 1'b0;
    check("done_not_early", done1, 0);
    @(negedge clk);
    check("done_one_cycle_after_last", done1, 1);
  endtask

  task automatic send_bits(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cfg_bit_valid = 1'b1;
      cfg_bit = tx[i];
    end
  endtask

  task automatic do_readback(input int len, input bit with2);
    for (int i = 0; i < len; i++) begin
      q_tail1.push_back(tx[i]);
      if (with2) q_tail2.push_back(tx[i]);
    end
    chk_tail2 = with2;
    tail_seen = 0;
    @(negedge clk); readback_req = 1'b1;
    @(negedge clk); readback_req = 1'b0;
    repeat (len + 10) @(negedge clk);
    check("tail_count", tail_seen, len);
    check("tail_queue_left", q_tail1.size(), 0);
    check("tail_valid_low_after", tail_valid1, 0);
    chk_tail2 = 1'b0;
  endtask

  task automatic rd1(input logic [6:0] a, input logic [31:0] e, input string nm);
    @(negedge clk) rd_addr = a;
    @(negedge clk) check(nm, rd_data1, e);
  endtask

  task automatic rd2(input logic a, input logic [31:0] e, input string nm);
    @(negedge clk) rd_addr2 = a;
    @(negedge clk) check(nm, rd_data2, e);
  endtask

  task automatic pulse_cfg_reset();
    @(negedge clk) cfg_reset = 1'b1;
    @(negedge clk) cfg_reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; cfg_reset = 1'b0; cfg_bit_valid = 1'b0; cfg_bit = 1'b0;
    cfg_len = '0; exp_checksum = '0; readback_req = 1'b0; rd_addr = '0; rd_addr2 = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {done1, ok1, err1, ovf1, tail_valid1, rd_data1}, 0);
    @(negedge clk) reset = 1'b1;

    // Bits offered with cfg_len==0 must be ignored in IDLE.
    repeat (5) begin
      @(negedge clk); cfg_bit_valid = 1'b1; cfg_bit = 1'b1;
    end
    @(negedge clk) cfg_bit_valid = 1'b0;

    // Full word, matching checksum.
    tx.delete(); push_word(32'h01020304, 32);
    expect_done(1, 0, 0, 0);
    run_load(32, 32'h0018000B, 1'b0);
    rd1(7'd0, 32'h01020304, "t1_mem0");
    cfg_len = 16'd32;
    repeat (40) begin
      @(negedge clk); cfg_bit_valid = 1'b1; cfg_bit = 1'b0;
    end
    @(negedge clk) cfg_bit_valid = 1'b0;
    rd1(7'd0, 32'h01020304, "t1_done_ignores_bits");
    do_readback(32, 1'b1);

    // Partial word with gaps, wrong expected checksum.
    pulse_cfg_reset();
    tx.delete(); push_word(32'h00000ABC, 12);
    expect_done(0, 1, 0, 0);
    run_load(12, 32'h00000000, 1'b1);
    rd1(7'd0, 32'hABC00000, "t2_mem0_left_aligned");
    do_readback(12, 1'b0);

    // 2400 ones: A wraps the modulus; small store overflows.
    pulse_cfg_reset();
    tx.delete();
    for (int i = 0; i < 2400; i++) tx.push_back(1'b1);
    expect_done(1, 0, 0, 1);
    run_load(2400, 32'hB90F2AE4, 1'b1);
    rd1(7'd74, 32'hFFFFFFFF, "t3_mem_last_word");
    do_readback(2400, 1'b0);

    // Three words into a 2-word store.
    pulse_cfg_reset();
    tx.delete();
    push_word(32'h11111111, 32); push_word(32'h22222222, 32); push_word(32'h33333333, 32);
    expect_done(1, 0, 0, 1);
    run_load(96, 32'h08480199, 1'b0);
    rd1(7'd2, 32'h33333333, "t4_big_mem2");
    rd2(1'b0, 32'h11111111, "t4_small_mem0");
    rd2(1'b1, 32'h22222222, "t4_small_mem1");

    pulse_cfg_reset();
    check("cfg_reset_clears_flags", {done1, ok1, done2, ok2, ovf2}, 0);

    // cfg_reset arriving with bit 17 aborts the load; a fresh load must align from bit 0.
    tx.delete(); push_word(32'h01020304, 32);
    cfg_len = 16'd32;
    send_bits(17);
    @(negedge clk); cfg_bit_valid = 1'b1; cfg_bit = tx[17]; cfg_reset = 1'b1;
    @(negedge clk); cfg_bit_valid = 1'b0; cfg_reset = 1'b0;
    check("cfg_reset_midload_flags", {done1, ok1, err1, ovf1, tail_valid1}, 0);
    expect_done(1, 0, 0, 0);
    run_load(32, 32'h0018000B, 1'b0);

    // Async reset takes effect without a clock edge.
    @(negedge clk); #2 reset = 1'b0;
    #1 check("async_reset_clear", {done1, ok1, err1, rd_data1}, 0);
    @(negedge clk) reset = 1'b1;
    send_bits(17);
    @(negedge clk); cfg_bit = tx[17]; #2 reset = 1'b0;
    @(negedge clk); cfg_bit_valid = 1'b0; reset = 1'b1;
    expect_done(1, 0, 0, 0);
    run_load(32, 32'h0018000B, 1'b0);
    rd1(7'd0, 32'h01020304, "t6_mem0_after_reload");

    repeat (5) @(negedge clk);
    check("done1_queue_empty", q_done1.size(), 0);
    check("done2_queue_empty", q_done2.size(), 0);
    check("tail2_queue_empty", q_tail2.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
